tug3_rx_sched: RTL

//  Sequencer for three tug3_rx channels. Demultiplexes a byte-wide VC-4 payload into three

---
 rtl/tug3_rx_sched_if.sv | 28 ++
 rtl/tug3_rx_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tug3_rx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : tug3_rx_sched_if
//  Brief    : VC-4 byte input bus and TUG-3 demux output bus of tug3_rx_sched.
//  Revision : 1.0  initial release
// ============================================================================
interface tug3_rx_sched_if #(
    parameter int WIDTH = 8
);
    logic             vc4_vld;
    logic             vc4_sof;
    logic [WIDTH-1:0] vc4_din;
    logic [2:0]       tug_en;
    logic [2:0]       tug_sof;
    logic [WIDTH-1:0] tug_dout;
    logic             poh_vld;

    modport master (
        output vc4_vld, vc4_sof, vc4_din,
        input  tug_en, tug_sof, tug_dout, poh_vld
    );

    modport slave (
        input  vc4_vld, vc4_sof, vc4_din,
        output tug_en, tug_sof, tug_dout, poh_vld
    );
endinterface
`default_nettype wire

// File: rtl/tug3_rx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tug3_rx_sched
//  Brief    : VC-4 row/column tracker that demuxes the payload into three
//             byte-interleaved TUG-3 streams, with J1 flywheel and realign.
//  Revision : 1.0  initial release
// ============================================================================
module tug3_rx_sched #(
    parameter int WIDTH    = 8,
    parameter int NCOL     = 261,
    parameter int NROW     = 9,
    parameter int MISS_MAX = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    tug3_rx_sched_if.slave   bus,
    input  wire logic [2:0]  i_tug_mask,
    output logic             o_frm_err,
    output logic             o_in_sync
);
    localparam int c_COL_W  = $clog2(NCOL);
    localparam int c_ROW_W  = $clog2(NROW);
    localparam int c_MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(NCOL - 1);
    localparam logic [c_COL_W-1:0]  c_FIRST_TUG = c_COL_W'(3);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(NROW - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_MAX - 1);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_SYNC = 1'b1
    } state_t;

    state_t               r_state, w_state;
    logic [c_COL_W-1:0]   r_col, w_col, w_ecol;
    logic [c_ROW_W-1:0]   r_row, w_row, w_erow;
    logic [1:0]           r_phase, w_phase, w_ph_cur;
    logic [c_MISS_W-1:0]  r_miss, w_miss;
    logic [2:0]           r_mask_q, w_mask_q;
    logic [2:0]           r_tug_en, w_en;
    logic [2:0]           r_tug_sof, w_sof;
    logic [WIDTH-1:0]     r_tug_dout;
    logic                 r_poh_vld, w_poh;
    logic                 r_frm_err, w_err;
    logic                 w_emit;
    logic                 w_at_j1;

    assign w_at_j1 = (r_col == '0) && (r_row == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state;
        end
    end

    // w_ecol/w_erow is the position this byte is treated as: the tracked
    // position, or (0,0) when a sof locks or realigns the counters.
    always_comb begin
        w_state  = r_state;
        w_col    = r_col;
        w_row    = r_row;
        w_phase  = r_phase;
        w_miss   = r_miss;
        w_mask_q = r_mask_q;
        w_en     = 3'b000;
        w_sof    = 3'b000;
        w_poh    = 1'b0;
        w_err    = 1'b0;
        w_emit   = 1'b0;
        w_ecol   = r_col;
        w_erow   = r_row;
        w_ph_cur = r_phase;
        if (bus.vc4_vld) begin
            case (r_state)
                S_HUNT: begin
                    if (bus.vc4_sof) begin
                        w_state = S_SYNC;
                        w_emit  = 1'b1;
                        w_ecol  = '0;
                        w_erow  = '0;
                        w_miss  = '0;
                    end
                end
                S_SYNC: begin
                    w_emit = 1'b1;
                    if (bus.vc4_sof) begin
                        w_miss = '0;
                        if (!w_at_j1) begin
                            w_err  = 1'b1;
                            w_ecol = '0;
                            w_erow = '0;
                        end
                    end else if (w_at_j1) begin
                        w_err = 1'b1;
                        if (r_miss == c_MISS_LAST) begin
                            w_state = S_HUNT;
                            w_emit  = 1'b0;
                            w_miss  = '0;
                        end else begin
                            w_miss = r_miss + c_MISS_W'(1);
                        end
                    end
                end
                default: w_state = S_HUNT;
            endcase

            if (w_emit) begin
                if (w_ecol == '0) begin
                    w_poh = 1'b1;
                    if (w_erow == '0) begin
                        w_mask_q = i_tug_mask;
                        w_sof    = i_tug_mask;
                    end
                end else if (w_ecol >= c_FIRST_TUG) begin
                    w_ph_cur = (w_ecol == c_FIRST_TUG) ? 2'd0 : r_phase;
                    w_en     = (3'b001 << w_ph_cur) & r_mask_q;
                    w_phase  = (w_ph_cur == 2'd2) ? 2'd0 : w_ph_cur + 2'd1;
                end
                if (w_ecol == c_LAST_COL) begin
                    w_col = '0;
                    w_row = (w_erow == c_LAST_ROW) ? '0 : w_erow + c_ROW_W'(1);
                end else begin
                    w_col = w_ecol + c_COL_W'(1);
                    w_row = w_erow;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_phase    <= 2'd0;
            r_miss     <= '0;
            r_mask_q   <= 3'b000;
            r_tug_en   <= 3'b000;
            r_tug_sof  <= 3'b000;
            r_tug_dout <= '0;
            r_poh_vld  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_col     <= w_col;
            r_row     <= w_row;
            r_phase   <= w_phase;
            r_miss    <= w_miss;
            r_mask_q  <= w_mask_q;
            r_tug_en  <= w_en;
            r_tug_sof <= w_sof;
            r_poh_vld <= w_poh;
            r_frm_err <= w_err;
            if (bus.vc4_vld) begin
                r_tug_dout <= bus.vc4_din;
            end
        end
    end

    assign bus.tug_en   = r_tug_en;
    assign bus.tug_sof  = r_tug_sof;
    assign bus.tug_dout = r_tug_dout;
    assign bus.poh_vld  = r_poh_vld;
    assign o_frm_err    = r_frm_err;
    assign o_in_sync    = (r_state == S_SYNC);
endmodule
`default_nettype wire
